// File: rtl/nand_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : nand_read_sequencer
// Brief   : NAND page-read return path: waits out R/B busy, strobes RE and
//           packs IOX bytes little-endian into 32-bit valid/ready words.
// Revision: 1.0 - initial release
// ============================================================================
module nand_read_sequencer #(
    parameter int TWB_CYCLES     = 4,
    parameter int RE_LOW_CYCLES  = 2,
    parameter int RE_HIGH_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] byte_count,
    input  logic        RB,
    input  logic [7:0]  IOX,
    output logic        RE,
    output logic        CE,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic        word_last,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int c_max_ab  = (TWB_CYCLES > TIMEOUT_CYCLES) ? TWB_CYCLES : TIMEOUT_CYCLES;
    localparam int c_max_cd  = (RE_LOW_CYCLES > RE_HIGH_CYCLES) ? RE_LOW_CYCLES : RE_HIGH_CYCLES;
    localparam int c_max_cnt = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cw      = $clog2(c_max_cnt + 1);

    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_twb_last = c_cw'(TWB_CYCLES - 1);
    localparam logic [c_cw-1:0] c_to_last  = c_cw'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_rlo_last = c_cw'(RE_LOW_CYCLES - 1);
    localparam logic [c_cw-1:0] c_rhi_last = c_cw'(RE_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TWB     = 3'd1,
        ST_WAIT_RB = 3'd2,
        ST_RE_LO   = 3'd3,
        ST_RE_HI   = 3'd4,
        ST_PUSH    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [11:0]       len_q, len_d;
    logic [11:0]       idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              re_q, re_d;
    logic              ce_q, ce_d;
    logic              rb_s1_q, rb_s2_q;
    logic              all_bytes;

    assign all_bytes = (idx_q == len_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
        done_d  = 1'b0;
        error_d = 1'b0;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (start) begin
                    len_d   = byte_count;
                    idx_d   = '0;
                    asm_d   = '0;
                    state_d = (byte_count == 12'd0) ? ST_DONE : ST_TWB;
                end
            end
            ST_TWB: begin
                if (cnt_q == c_twb_last) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RB;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_WAIT_RB: begin
                if (rb_s2_q) begin
                    cnt_d   = '0;
                    state_d = ST_RE_LO;
                end else if (cnt_q == c_to_last) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_RE_LO: begin
                // Sample IOX on the edge that ends the low pulse (RE rising).
                if (cnt_q == c_rlo_last) begin
                    asm_d[{idx_q[1:0], 3'b000} +: 8] = IOX;
                    idx_d   = idx_q + 12'd1;
                    cnt_d   = '0;
                    state_d = ST_RE_HI;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_RE_HI: begin
                if (cnt_q == c_rhi_last) begin
                    cnt_d   = '0;
                    state_d = (all_bytes || (idx_q[1:0] == 2'd0)) ? ST_PUSH : ST_RE_LO;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            ST_PUSH: begin
                if (!valid_q || word_ready) begin
                    data_d  = asm_q;
                    valid_d = 1'b1;
                    last_d  = all_bytes;
                    asm_d   = '0;
                    state_d = all_bytes ? ST_DONE : ST_RE_LO;
                end
            end
            ST_DONE: begin
                if (!valid_q) begin
                    done_d  = 1'b1;
                    error_d = err_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes registered from next state so the NAND pins never glitch.
        re_d = (state_d != ST_RE_LO);
        ce_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            re_q    <= 1'b1;
            ce_q    <= 1'b1;
            rb_s1_q <= 1'b0;
            rb_s2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
            error_q <= error_d;
            re_q    <= re_d;
            ce_q    <= ce_d;
            rb_s1_q <= RB;
            rb_s2_q <= rb_s1_q;
        end
    end

    assign RE         = re_q;
    assign CE         = ce_q;
    assign word_data  = data_q;
    assign word_valid = valid_q;
    assign word_last  = last_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule
`default_nettype wire
